// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Branch predictor and EX-stage branch resolver. A direct-mapped branch
// target buffer (BTB) and a 2-bit saturating bimodal counter per entry
// predict the next fetch PC. The EX side resolves JAL/JALR and conditional
// branches with RV32 compare semantics. It requests a redirect only when the
// prediction that travelled with the instruction was wrong. The tables are
// trained on the rising clock edge.
//
// Optional feature (macro BPU_STATS_EN): adds STAT_BRANCHES and
// STAT_MISPREDICTS counters. When the macro is undefined, the ports and the
// counters are absent.
//
// Ports
//   CLK              rising-edge clock
//   RESET_N          asynchronous active-low reset
//   IF_PC            fetch PC to predict for
//   PRED_TAKEN       prediction for IF_PC
//   PRED_TARGET      predicted next fetch PC
//   EX_VALID         EX stage holds a live instruction
//   EX_JUMP          JAL/JALR in EX (has priority over EX_BRANCH)
//   EX_BRANCH        conditional branch in EX
//   EX_FUNC3         branch condition code
//   EX_OUT1/EX_OUT2  rs1/rs2 operand values
//   EX_TARGET        computed control-flow target
//   EX_PC            PC of the EX instruction
//   EX_PRED_TAKEN    prediction carried down the pipe with the instruction
//   EX_PRED_TARGET   predicted target carried down the pipe
//   REDIRECT         mispredict: load REDIRECT_PC, flush IF/ID
//   REDIRECT_PC      architecturally correct next PC
//   STAT_BRANCHES    (BPU_STATS_EN) count of trained instructions
//   STAT_MISPREDICTS (BPU_STATS_EN) count of redirect cycles
// ---------------------------------------------------------------------------
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [XLEN-1:0] IF_PC,
  output logic            PRED_TAKEN,
  output logic [XLEN-1:0] PRED_TARGET,
  input  logic            EX_VALID,
  input  logic            EX_JUMP,
  input  logic            EX_BRANCH,
  input  logic [2:0]      EX_FUNC3,
  input  logic [XLEN-1:0] EX_OUT1,
  input  logic [XLEN-1:0] EX_OUT2,
  input  logic [XLEN-1:0] EX_TARGET,
  input  logic [XLEN-1:0] EX_PC,
  input  logic            EX_PRED_TAKEN,
  input  logic [XLEN-1:0] EX_PRED_TARGET,
  output logic            REDIRECT,
  output logic [XLEN-1:0] REDIRECT_PC
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]     STAT_BRANCHES,
  output logic [31:0]     STAT_MISPREDICTS
`endif
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Branch condition evaluation. Unlisted codes (010/011) evaluate false.
  function automatic logic branch_cond(input logic [2:0]      f3,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    a_s = a;
    b_s = b;
    case (f3)
      F3_BEQ:  branch_cond = (a == b);
      F3_BNE:  branch_cond = (a != b);
      F3_BLT:  branch_cond = (a_s < b_s);
      F3_BGE:  branch_cond = (a_s >= b_s);
      F3_BLTU: branch_cond = (a < b);
      F3_BGEU: branch_cond = (a >= b);
      default: branch_cond = 1'b0;
    endcase
  endfunction

  function automatic logic branch_legal(input logic [2:0] f3);
    branch_legal = (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  // Saturating 2-bit bimodal counter steps.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    ctr_inc = (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    ctr_dec = (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Table state. valid/ctr are control and reset. tag/target/is_jump are
  // data and are only meaningful while valid is set.
  logic             valid_q   [BTB_ENTRIES];
  logic [1:0]       ctr_q     [BTB_ENTRIES];
  logic             is_jump_q [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q     [BTB_ENTRIES];
  logic [XLEN-1:0]  target_q  [BTB_ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [XLEN-1:0]  if_pc_plus4;

  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [XLEN-1:0]  ex_pc_plus4;
  logic             ex_legal;
  logic             ex_cond;
  logic             ex_taken;
  logic [XLEN-1:0]  ex_next;
  logic             ex_mispredict;

  logic             train_jump;
  logic             train_taken;
  logic             train_not_taken;
  logic             train_any;
  logic             stale_clear;

  // IF lookup: reads the registered tables only, so a same-cycle EX write
  // to the same index is not visible until after the edge.
  always_comb begin
    if_idx      = IF_PC[IDX_W+1:2];
    if_tag      = IF_PC[XLEN-1:IDX_W+2];
    if_pc_plus4 = IF_PC + XLEN'(4);
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    PRED_TAKEN  = RESET_N && if_hit && (is_jump_q[if_idx] || ctr_q[if_idx][1]);
    PRED_TARGET = PRED_TAKEN ? target_q[if_idx] : if_pc_plus4;
  end

  // EX resolution. JUMP takes priority over BRANCH.
  always_comb begin
    ex_idx        = EX_PC[IDX_W+1:2];
    ex_tag        = EX_PC[XLEN-1:IDX_W+2];
    ex_hit        = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_pc_plus4   = EX_PC + XLEN'(4);
    ex_legal      = branch_legal(EX_FUNC3);
    ex_cond       = branch_cond(EX_FUNC3, EX_OUT1, EX_OUT2);
    ex_taken      = EX_JUMP || (EX_BRANCH && ex_legal && ex_cond);
    ex_next       = ex_taken ? EX_TARGET : ex_pc_plus4;
    ex_mispredict = EX_VALID &&
                    ((EX_PRED_TAKEN != ex_taken) ||
                     (ex_taken && (EX_PRED_TARGET != EX_TARGET)));
    REDIRECT      = RESET_N && ex_mispredict;
    REDIRECT_PC   = RESET_N ? ex_next : '0;
  end

  // Training qualifiers. Illegal branch codes are neither trained nor
  // treated as stale entries. Only a non-control instruction that was
  // predicted taken invalidates its entry.
  always_comb begin
    train_jump      = EX_VALID && EX_JUMP;
    train_taken     = EX_VALID && !EX_JUMP && EX_BRANCH && ex_legal && ex_cond;
    train_not_taken = EX_VALID && !EX_JUMP && EX_BRANCH && ex_legal && !ex_cond;
    train_any       = train_jump || train_taken || train_not_taken;
    stale_clear     = EX_VALID && !EX_JUMP && !EX_BRANCH && EX_PRED_TAKEN;
  end

  // Control state: valid bits and bimodal counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (train_jump) begin
      valid_q[ex_idx] <= 1'b1;
      ctr_q[ex_idx]   <= 2'b11;
    end else if (train_taken) begin
      valid_q[ex_idx] <= 1'b1;
      ctr_q[ex_idx]   <= ex_hit ? ctr_inc(ctr_q[ex_idx]) : 2'b10;
    end else if (train_not_taken) begin
      // A not-taken miss leaves the table alone; no allocation.
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_dec(ctr_q[ex_idx]);
      end
    end else if (stale_clear) begin
      valid_q[ex_idx] <= 1'b0;
    end
  end

  // Entry payload. A taken-branch hit rewrites the same tag, so the
  // hit and allocate cases share one write.
  always_ff @(posedge CLK) begin
    if (train_jump || train_taken) begin
      tag_q[ex_idx]     <= ex_tag;
      target_q[ex_idx]  <= EX_TARGET;
      is_jump_q[ex_idx] <= train_jump;
    end
  end

`ifdef BPU_STATS_EN
  // Free-running event counters; both wrap at 2^32.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      STAT_BRANCHES    <= '0;
      STAT_MISPREDICTS <= '0;
    end else begin
      if (train_any) begin
        STAT_BRANCHES <= STAT_BRANCHES + 32'd1;
      end
      if (REDIRECT) begin
        STAT_MISPREDICTS <= STAT_MISPREDICTS + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
  localparam int XLEN = 32;
  localparam int N    = 4;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic [XLEN-1:0]   IF_PC = '0;
  logic              PRED_TAKEN;
  logic [XLEN-1:0]   PRED_TARGET;
  logic              EX_VALID = 1'b0;
  logic              EX_JUMP = 1'b0;
  logic              EX_BRANCH = 1'b0;
  logic [2:0]        EX_FUNC3 = '0;
  logic [XLEN-1:0]   EX_OUT1 = '0;
  logic [XLEN-1:0]   EX_OUT2 = '0;
  logic [XLEN-1:0]   EX_TARGET = '0;
  logic [XLEN-1:0]   EX_PC = '0;
  logic              EX_PRED_TAKEN = 1'b0;
  logic [XLEN-1:0]   EX_PRED_TARGET = '0;
  logic              REDIRECT;
  logic [XLEN-1:0]   REDIRECT_PC;
`ifdef BPU_STATS_EN
  logic [31:0]       STAT_BRANCHES;
  logic [31:0]       STAT_MISPREDICTS;
`endif

  branch_predict_unit #(.XLEN(XLEN), .BTB_ENTRIES(N)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IF_PC(IF_PC),
    .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET),
    .EX_VALID(EX_VALID), .EX_JUMP(EX_JUMP), .EX_BRANCH(EX_BRANCH),
    .EX_FUNC3(EX_FUNC3), .EX_OUT1(EX_OUT1), .EX_OUT2(EX_OUT2),
    .EX_TARGET(EX_TARGET), .EX_PC(EX_PC),
    .EX_PRED_TAKEN(EX_PRED_TAKEN), .EX_PRED_TARGET(EX_PRED_TARGET),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC)
`ifdef BPU_STATS_EN
    , .STAT_BRANCHES(STAT_BRANCHES), .STAT_MISPREDICTS(STAT_MISPREDICTS)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference model: one record per BTB slot, counter kept as an integer.
  typedef struct {
    bit          valid;
    bit          is_jump;
    logic [31:0] tagv;
    logic [31:0] target;
    int          ctr;
  } ent_t;

  typedef struct {
    bit          rst_n;
    logic [31:0] if_pc;
    bit          v;
    bit          j;
    bit          b;
    logic [2:0]  f3;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] tgt;
    logic [31:0] pc;
    bit          ept;
    logic [31:0] eptg;
  } stim_t;

  typedef struct {
    string       name;
    bit          pt;
    logic [31:0] ptg;
    bit          rd;
    logic [31:0] rpc;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  ent_t        m [N];
  exp_t        sbq [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cnt_b = 0;
  logic [31:0] cnt_m = 0;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m[i].valid = 0;
      m[i].ctr   = 1;
    end
    cnt_b = 0;
    cnt_m = 0;
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output bit pt,
                                        output logic [31:0] ptg);
    int  i;
    bit  hit;
    i   = idx_of(pc);
    hit = m[i].valid && (m[i].tagv == tag_of(pc));
    pt  = hit && (m[i].is_jump || m[i].ctr >= 2);
    ptg = pt ? m[i].target : pc + 32'd4;
  endfunction

  function automatic bit cond_of(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 0;
    endcase
  endfunction

  function automatic stim_t idle(logic [31:0] if_pc);
    stim_t s;
    s.rst_n = 1; s.if_pc = if_pc; s.v = 0; s.j = 0; s.b = 0; s.f3 = 0;
    s.o1 = 0; s.o2 = 0; s.tgt = 0; s.pc = 0; s.ept = 0; s.eptg = 0;
    return s;
  endfunction

  function automatic stim_t ex(logic [31:0] if_pc, bit j, bit b, logic [2:0] f3,
                               logic [31:0] o1, logic [31:0] o2, logic [31:0] tgt,
                               logic [31:0] pc, bit ept, logic [31:0] eptg);
    stim_t s;
    s = idle(if_pc);
    s.v = 1; s.j = j; s.b = b; s.f3 = f3; s.o1 = o1; s.o2 = o2;
    s.tgt = tgt; s.pc = pc; s.ept = ept; s.eptg = eptg;
    return s;
  endfunction

  // Drive one cycle, predict its outputs from pre-edge model state, then
  // apply the edge's training to the model.
  task automatic step(input stim_t s, input string name);
    exp_t        e;
    bit          legal;
    bit          taken;
    bit          hit;
    int          j;
    @(posedge CLK);
    #1;
    RESET_N = s.rst_n; IF_PC = s.if_pc; EX_VALID = s.v; EX_JUMP = s.j;
    EX_BRANCH = s.b; EX_FUNC3 = s.f3; EX_OUT1 = s.o1; EX_OUT2 = s.o2;
    EX_TARGET = s.tgt; EX_PC = s.pc; EX_PRED_TAKEN = s.ept; EX_PRED_TARGET = s.eptg;
    e.name = name;
    if (!s.rst_n) begin
      model_reset();
      e.pt = 0; e.ptg = s.if_pc + 32'd4; e.rd = 0; e.rpc = 0; e.sb = 0; e.sm = 0;
    end else begin
      model_predict(s.if_pc, e.pt, e.ptg);
      legal = (s.f3 != 3'd2) && (s.f3 != 3'd3);
      taken = s.j || (s.b && legal && cond_of(s.f3, s.o1, s.o2));
      e.rpc = taken ? s.tgt : s.pc + 32'd4;
      e.rd  = s.v && ((s.ept != taken) || (taken && s.eptg != s.tgt));
      e.sb  = cnt_b;
      e.sm  = cnt_m;
      j   = idx_of(s.pc);
      hit = m[j].valid && (m[j].tagv == tag_of(s.pc));
      if (s.v && (s.j || (s.b && legal))) begin
        cnt_b++;
        if (s.j) begin
          m[j].valid = 1; m[j].is_jump = 1; m[j].tagv = tag_of(s.pc);
          m[j].target = s.tgt; m[j].ctr = 3;
        end else if (taken) begin
          m[j].ctr = hit ? ((m[j].ctr < 3) ? m[j].ctr + 1 : 3) : 2;
          m[j].valid = 1; m[j].is_jump = 0; m[j].tagv = tag_of(s.pc);
          m[j].target = s.tgt;
        end else if (hit) begin
          m[j].ctr = (m[j].ctr > 0) ? m[j].ctr - 1 : 0;
        end
      end else if (s.v && !s.j && !s.b && s.ept) begin
        m[j].valid = 0;
      end
      if (e.rd) cnt_m++;
    end
    sbq.push_back(e);
  endtask

  task automatic chk(input string nm, input string fld, input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s got=%h want=%h", nm, fld, got, want);
    end
  endtask

  // Monitor: outputs are combinational, so every driven cycle is one
  // transaction, sampled at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk(e.name, "pred_taken",  {31'd0, PRED_TAKEN}, {31'd0, e.pt});
        chk(e.name, "pred_target", PRED_TARGET, e.ptg);
        chk(e.name, "redirect",    {31'd0, REDIRECT}, {31'd0, e.rd});
        chk(e.name, "redirect_pc", REDIRECT_PC, e.rpc);
`ifdef BPU_STATS_EN
        chk(e.name, "stat_branches",    STAT_BRANCHES, e.sb);
        chk(e.name, "stat_mispredicts", STAT_MISPREDICTS, e.sm);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] pick_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  function automatic logic [31:0] pick_op();
    logic [31:0] vals [6];
    vals[0] = 32'h0; vals[1] = 32'h1; vals[2] = 32'hFFFF_FFFF;
    vals[3] = 32'h8000_0000; vals[4] = 32'h7FFF_FFFF; vals[5] = 32'h5;
    return vals[$urandom_range(0, 5)];
  endfunction

  initial begin
    stim_t s;
    int    k;
    s = idle(32'h100); s.rst_n = 0;
    step(s, "in_reset");
    step(s, "in_reset2");
    step(idle(32'h100), "reset_lookup");
    step(idle(32'h40),  "reset_miss40");
    // BEQ taken, predicted not-taken
    step(ex(32'h40, 0, 1, 3'd0, 5, 5, 32'h80, 32'h40, 0, 0), "beq_taken");
    step(idle(32'h40), "beq_pred");
    step(ex(32'h40, 0, 1, 3'd0, 5, 6, 32'h80, 32'h40, 1, 32'h80), "beq_nt1");
    step(ex(32'h40, 0, 1, 3'd0, 5, 6, 32'h80, 32'h40, 0, 0), "beq_nt2");
    step(idle(32'h40), "beq_pred00");
    step(ex(32'h40, 0, 1, 3'd0, 5, 6, 32'h80, 32'h40, 0, 0), "beq_nt3");
    step(idle(32'h40), "beq_still00");
    // Signed vs unsigned compare
    step(ex(32'h0, 0, 1, 3'd4, 32'hFFFF_FFFF, 1, 32'h90, 32'h50, 0, 0), "blt_neg");
    step(ex(32'h0, 0, 1, 3'd6, 32'hFFFF_FFFF, 1, 32'h98, 32'h54, 0, 0), "bltu_big");
    step(ex(32'h60, 0, 1, 3'd2, 1, 1, 32'hA0, 32'h60, 1, 32'hA0), "illegal_f3");
    step(idle(32'h60), "illegal_untouched");
    // JALR retarget; also JUMP priority with a branch flag set
    step(ex(32'h200, 1, 1, 3'd1, 7, 7, 32'h300, 32'h200, 0, 0), "jalr_first");
    step(idle(32'h200), "jalr_pred");
    step(ex(32'h200, 1, 0, 3'd0, 0, 0, 32'h340, 32'h200, 1, 32'h300), "jalr_retarget");
    step(idle(32'h200), "jalr_newtgt");
    // Aliasing at index 0
    step(ex(32'h10, 0, 1, 3'd5, 3, 3, 32'h500, 32'h10, 0, 0), "alias_a");
    step(idle(32'h10), "alias_a_hit");
    step(ex(32'h10, 0, 1, 3'd7, 9, 3, 32'h600, 32'h20, 0, 0), "alias_b");
    step(idle(32'h10), "alias_a_evicted");
    step(idle(32'h20), "alias_b_hit");
    // Stale entry on a non-control instruction
    step(ex(32'h20, 0, 0, 3'd0, 0, 0, 32'h600, 32'h20, 1, 32'h600), "stale");
    step(idle(32'h20), "stale_cleared");
    // Address wrap on PC+4
    step(ex(32'hFFFF_FFFC, 0, 1, 3'd1, 2, 2, 32'h8, 32'hFFFF_FFFC, 1, 32'h8), "wrap");
    // Mid-stream reset
    step(ex(32'h0, 1, 0, 3'd0, 0, 0, 32'h700, 32'h4, 0, 0), "pre_reset_jump");
    s = idle(32'h4); s.rst_n = 0;
    step(s, "mid_reset");
    step(idle(32'h4), "post_reset_miss");
    step(idle(32'h200), "post_reset_miss2");
    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      s = idle(pick_pc());
      s.v  = ($urandom_range(0, 7) != 0);
      k    = int'($urandom_range(0, 9));
      s.j  = (k <= 1);
      s.b  = (k >= 2 && k <= 7) || (k == 0 && $urandom_range(0, 1) == 1);
      s.f3 = 3'($urandom_range(0, 7));
      s.o1 = pick_op(); s.o2 = pick_op();
      s.pc = pick_pc();
      s.tgt = ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h2000 + (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 3) != 0) begin
        model_predict(s.pc, s.ept, s.eptg);
      end else begin
        s.ept = 1'($urandom_range(0, 1)); s.eptg = 32'h1000;
      end
      if ($urandom_range(0, 199) == 0) s.rst_n = 0;
      step(s, "rand");
    end
    @(negedge CLK);
    @(negedge CLK);
    chk("drain", "pending", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
